draw_map_scroll: RTL

DRAW_MAP_SCROLL -- requirements
Module: draw_map_scroll

---
 rtl/vga_if.sv | 16 +
 rtl/draw_map_scroll.sv | 136 +++++++++++++
 2 files changed

// File: rtl/vga_if.sv
// VGA timing + colour bundle: 11-bit counters, sync/blank strobes, 12-bit rgb.
// The in/out modports are the sink and source views; slave/master are aliases of them.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_map_scroll.sv
// Draws a horizontally scrolling, wrapping tile map into a VGA stream.
// Optional macro MAP_TRANSPARENCY_EN: texels equal to TRANSP_KEY let the background through.
module draw_map_scroll #(
    parameter int          XPOS       = 0,
    parameter int          YPOS       = 0,
    parameter int          SCALE_LOG2 = 2,
    parameter int          MAP_W_LOG2 = 9,
    parameter int          MAP_H_LOG2 = 7,
    parameter int          ROM_LAT    = 1,
    parameter logic [11:0] TRANSP_KEY = 12'hF0F
) (
    input  logic                               clk,
    input  logic                               rst,
    vga_if.in                                  in,
    vga_if.out                                 out,
    input  logic [MAP_W_LOG2-1:0]              map_ofset,
    input  logic [11:0]                        rgb_pixel,
    output logic [MAP_H_LOG2+MAP_W_LOG2-1:0]   pixel_adr,
    output logic                               frame_tick
);

    localparam int WIN_W_LOG2 = MAP_W_LOG2 + SCALE_LOG2;
    localparam int WIN_H_LOG2 = MAP_H_LOG2 + SCALE_LOG2;

`ifdef MAP_TRANSPARENCY_EN
    localparam logic TRANSP_EN = 1'b1;
`else
    localparam logic TRANSP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

    typedef struct packed {
        vga_t v;
        logic hit;
    } stage_t;

    logic [31:0]                       dx_s;
    logic [31:0]                       dy_s;
    logic                              hit_h_s;
    logic                              hit_v_s;
    logic [MAP_W_LOG2-1:0]             col_s;
    logic [MAP_H_LOG2-1:0]             row_s;
    stage_t                            stage_in_s;
    stage_t                            last_s;
    logic                              key_hit_s;
    logic [11:0]                       out_rgb_s;
    logic                              vblnk_rise_s;

    // Stage k holds the sample taken k+1 edges ago; the last stage lines up with rgb_pixel.
    stage_t                            pipe_r [0:ROM_LAT];
    vga_t                              out_r;
    logic [MAP_H_LOG2+MAP_W_LOG2-1:0]  pixel_adr_r;
    logic [MAP_W_LOG2-1:0]             active_ofs_r;
    logic                              vblnk_prev_r;
    logic                              frame_tick_r;

    // Window test and map coordinates of the incoming pixel.
    always_comb begin
        dx_s         = {21'd0, in.hcount} - 32'(XPOS);
        dy_s         = {21'd0, in.vcount} - 32'(YPOS);
        hit_h_s      = ({21'd0, in.hcount} >= 32'(XPOS)) && (dx_s < (32'd1 << WIN_W_LOG2));
        hit_v_s      = ({21'd0, in.vcount} >= 32'(YPOS)) && (dy_s < (32'd1 << WIN_H_LOG2));
        col_s        = dx_s[WIN_W_LOG2-1:SCALE_LOG2] + active_ofs_r;
        row_s        = dy_s[WIN_H_LOG2-1:SCALE_LOG2];
        vblnk_rise_s = in.vblnk & ~vblnk_prev_r;
        stage_in_s.v.hcount = in.hcount;
        stage_in_s.v.vcount = in.vcount;
        stage_in_s.v.hsync  = in.hsync;
        stage_in_s.v.vsync  = in.vsync;
        stage_in_s.v.hblnk  = in.hblnk;
        stage_in_s.v.vblnk  = in.vblnk;
        stage_in_s.v.rgb    = in.rgb;
        stage_in_s.hit      = hit_h_s & hit_v_s & ~in.hblnk & ~in.vblnk;
    end

    // Output colour select: texel on a hit unless it is the transparent key.
    always_comb begin
        last_s    = pipe_r[ROM_LAT];
        key_hit_s = TRANSP_EN && (rgb_pixel == TRANSP_KEY);
        if (last_s.hit && !key_hit_s) begin
            out_rgb_s = rgb_pixel;
        end else begin
            out_rgb_s = last_s.v.rgb;
        end
    end

    // Address, alignment pipeline, output register and per-frame scroll offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= ROM_LAT; k++) begin
                pipe_r[k] <= '0;
            end
            out_r        <= '0;
            pixel_adr_r  <= '0;
            active_ofs_r <= '0;
            vblnk_prev_r <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            pixel_adr_r <= {row_s, col_s};
            pipe_r[0]   <= stage_in_s;
            for (int k = 1; k <= ROM_LAT; k++) begin
                pipe_r[k] <= pipe_r[k-1];
            end
            out_r       <= last_s.v;
            out_r.rgb   <= out_rgb_s;
            vblnk_prev_r <= in.vblnk;
            frame_tick_r <= vblnk_rise_s;
            // Offset changes only at the start of vertical blank, so a frame never tears.
            if (vblnk_rise_s) begin
                active_ofs_r <= map_ofset;
            end else begin
                active_ofs_r <= active_ofs_r;
            end
        end
    end

    assign out.hcount = out_r.hcount;
    assign out.vcount = out_r.vcount;
    assign out.hsync  = out_r.hsync;
    assign out.vsync  = out_r.vsync;
    assign out.hblnk  = out_r.hblnk;
    assign out.vblnk  = out_r.vblnk;
    assign out.rgb    = out_r.rgb;
    assign pixel_adr  = pixel_adr_r;
    assign frame_tick = frame_tick_r;

endmodule
